// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking gate sequencer.
// Holds the gate FSM state encoding and the default hold time / slot count.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } gate_state_t;

    localparam int DEF_OPEN_SECS = 5;
    localparam int DEF_CAPACITY  = 8;

endpackage

// File: rtl/edge_tick.sv
// Rising-edge detector for a slow divided clock sampled as data on clk.
// The history flop resets high so a source already high at release gives no tick.
module edge_tick (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic tick
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign tick = sig & ~prev_q;

endmodule

// File: rtl/gate_sequencer.sv
// Single-barrier parking gate: round-robin entry/exit arbitration, occupancy count
// and a 1 Hz hold timer. Define GATE_WARN_EN to blink warn_lamp at 2 Hz while open.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | gate down, arbitrating entry/exit requests
// OPEN  | gate up, hold timer running (reloaded while a car is present)
// CLOSE | one-cycle gate-down settle before arbitration resumes
module gate_sequencer
    import parking_pkg::*;
#(
    parameter int OPEN_SECS = DEF_OPEN_SECS,
    parameter int CAPACITY  = DEF_CAPACITY,
    localparam int OCC_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_1Hz,
    input  logic             clk_2Hz,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_present,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             gate_open,
    output logic             warn_lamp,
    output logic [OCC_W-1:0] occupancy,
    output logic             full
);

    localparam int               HOLD_W    = $clog2(OPEN_SECS + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(OPEN_SECS);
    localparam logic [OCC_W-1:0]  OCC_MAX   = OCC_W'(CAPACITY);

    gate_state_t       state_q, state_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              prefer_exit_q, prefer_exit_d;
    logic              gate_open_q, gate_open_d;
    logic              tick1;
    logic              entry_ok;
    logic              exit_ok;

    edge_tick u_tick1 (
        .clk   (clk),
        .reset (reset),
        .sig   (clk_1Hz),
        .tick  (tick1)
    );

    assign full     = (occ_q == OCC_MAX);
    assign entry_ok = entry_req && !full;
    assign exit_ok  = exit_req && (occ_q != '0);

    always_comb begin
        state_d       = state_q;
        occ_d         = occ_q;
        hold_d        = hold_q;
        prefer_exit_d = prefer_exit_q;
        entry_grant   = 1'b0;
        exit_grant    = 1'b0;

        case (state_q)
            IDLE: begin
                if (entry_ok && (!exit_ok || !prefer_exit_q)) begin
                    entry_grant = 1'b1;
                end else if (exit_ok) begin
                    exit_grant = 1'b1;
                end

                if (entry_grant) begin
                    occ_d         = occ_q + 1'b1;
                    prefer_exit_d = 1'b1;
                    hold_d        = HOLD_INIT;
                    state_d       = OPEN;
                end else if (exit_grant) begin
                    occ_d         = occ_q - 1'b1;
                    prefer_exit_d = 1'b0;
                    hold_d        = HOLD_INIT;
                    state_d       = OPEN;
                end
            end
            OPEN: begin
                // A car in the barrier zone always wins over the timer.
                if (car_present) begin
                    hold_d = HOLD_INIT;
                end else if (hold_q == '0) begin
                    state_d = CLOSE;
                end else if (tick1) begin
                    hold_d = hold_q - 1'b1;
                end
            end
            CLOSE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            entry_grant = 1'b0;
            exit_grant  = 1'b0;
        end

        gate_open_d = (state_d == OPEN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            occ_q         <= '0;
            hold_q        <= '0;
            prefer_exit_q <= 1'b0;
            gate_open_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            occ_q         <= occ_d;
            hold_q        <= hold_d;
            prefer_exit_q <= prefer_exit_d;
            gate_open_q   <= gate_open_d;
        end
    end

    assign gate_open = gate_open_q;
    assign occupancy = occ_q;

`ifdef GATE_WARN_EN
    logic tick2;
    logic warn_q, warn_d;

    edge_tick u_tick2 (
        .clk   (clk),
        .reset (reset),
        .sig   (clk_2Hz),
        .tick  (tick2)
    );

    // Only blinks across cycles that stay in OPEN; any exit from OPEN clears it.
    always_comb begin
        warn_d = 1'b0;
        if (state_q == OPEN && state_d == OPEN) begin
            warn_d = warn_q ^ tick2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn_lamp = warn_q;
`else
    logic unused_clk_2hz;
    assign unused_clk_2hz = clk_2Hz;
    assign warn_lamp      = 1'b0;
`endif

endmodule
